// File: rtl/switch_pkg.sv
// Shared types and defaults for the switch event path.
package switch_pkg;

    localparam int NUM_BITS_DEF = 18;
    localparam int CNT_W_DEF    = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_e;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set bit at or above ptr_i, wrapping.
module rr_select
    import switch_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEF,
    parameter int IDX_W    = idx_width(NUM_BITS)
) (
    input  logic [NUM_BITS-1:0] req_i,
    input  logic [IDX_W-1:0]    ptr_i,
    output logic                found_o,
    output logic [IDX_W-1:0]    idx_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = 0; k < NUM_BITS; k++) begin
            int j;
            j = int'(ptr_i) + k;
            if (j >= NUM_BITS) j = j - NUM_BITS;
            if (!found_o && req_i[j]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/switch_event_arbiter.sv
// Latches switch edge pulses as sticky requests and serves them round-robin
// over a valid/ready handshake, counting edges lost to an already-pending bit.
module switch_event_arbiter
    import switch_pkg::*;
#(
    parameter int  NUM_BITS = NUM_BITS_DEF,
    parameter int  CNT_W    = CNT_W_DEF,
    localparam int IDX_W    = idx_width(NUM_BITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BITS-1:0] sw_edge,
    output logic                evt_valid,
    output logic [IDX_W-1:0]    evt_idx,
    input  logic                evt_ready,
    output logic [NUM_BITS-1:0] pending,
    output logic [CNT_W-1:0]    overrun_cnt
);

    arb_state_e          state_q, state_d;
    logic [NUM_BITS-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    ovr_q, ovr_d;

    logic                accept;
    logic [NUM_BITS-1:0] clr;
    logic                drop;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;

    rr_select #(
        .NUM_BITS (NUM_BITS),
        .IDX_W    (IDX_W)
    ) u_rr_select (
        .req_i   (pending_q),
        .ptr_i   (rr_ptr_q),
        .found_o (sel_found),
        .idx_o   (sel_idx)
    );

    assign accept = (state_q == OFFER) && evt_ready;
    assign clr    = accept ? (NUM_BITS'(1) << idx_q) : '0;

    // A new edge wins over the clear, so a bit re-hit on its accept cycle stays pending.
    assign pending_d = (pending_q & ~clr) | sw_edge;
    assign drop      = |(sw_edge & pending_q & ~clr);
    assign ovr_d     = (drop && (ovr_q != {CNT_W{1'b1}})) ? ovr_q + CNT_W'(1) : ovr_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    idx_d   = sel_idx;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    rr_ptr_d = (idx_q == IDX_W'(NUM_BITS - 1)) ? '0 : idx_q + IDX_W'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            rr_ptr_q  <= '0;
            ovr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            rr_ptr_q  <= rr_ptr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign evt_valid   = (state_q == OFFER);
    assign evt_idx     = idx_q;
    assign pending     = pending_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_switch_event_arbiter.sv
// Directed bench for switch_event_arbiter with hand-computed expectations.
module tb_switch_event_arbiter;

    localparam int NB = 18;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] sw_edge;
    logic          evt_valid;
    logic [4:0]    evt_idx;
    logic          evt_ready;
    logic [NB-1:0] pending;
    logic [7:0]    overrun_cnt;

    int total = 0;
    int bad   = 0;

    switch_event_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_edge     (sw_edge),
        .evt_valid   (evt_valid),
        .evt_idx     (evt_idx),
        .evt_ready   (evt_ready),
        .pending     (pending),
        .overrun_cnt (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for an offer, then check its index.
    task automatic wait_offer(input string tag, input int exp_idx);
        int n;
        n = 0;
        while (!evt_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
        chk({tag, "_idx"}, 32'(evt_idx), 32'(exp_idx));
    endtask

    initial begin
        rst_n     = 1'b0;
        sw_edge   = '0;
        evt_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_idx", 32'(evt_idx), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ovr", 32'(overrun_cnt), 32'd0);
        rst_n = 1'b1;

        // Reset mid-offer, with an overrun recorded beforehand.
        tick();
        sw_edge = NB'(1) << 5;
        tick();
        tick();
        sw_edge = '0;
        chk("mid_valid", 32'(evt_valid), 32'd1);
        chk("mid_idx", 32'(evt_idx), 32'd5);
        chk("mid_ovr", 32'(overrun_cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(evt_valid), 32'd0);
        chk("async_pending", 32'(pending), 32'd0);
        chk("async_ovr", 32'(overrun_cnt), 32'd0);
        #3 rst_n = 1'b1;
        evt_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("post_rst_valid", 32'(evt_valid), 32'd0);
        chk("post_rst_pending", 32'(pending), 32'd0);

        // Single event latency.
        sw_edge = NB'(1) << 5;
        tick();
        sw_edge = '0;
        chk("lat_pending_k", 32'(pending), 32'h00020);
        chk("lat_valid_k", 32'(evt_valid), 32'd0);
        tick();
        chk("lat_valid_k1", 32'(evt_valid), 32'd1);
        chk("lat_idx_k1", 32'(evt_idx), 32'd5);
        tick();
        chk("lat_pending_k2", 32'(pending), 32'd0);
        chk("lat_valid_k2", 32'(evt_valid), 32'd0);

        // Round-robin with wrap: pointer is 6, so order is 17, 0, 3.
        sw_edge = (NB'(1) << 0) | (NB'(1) << 3) | (NB'(1) << 17);
        tick();
        sw_edge = '0;
        wait_offer("rr_first", 17);
        tick();
        wait_offer("rr_second", 0);
        tick();
        wait_offer("rr_third", 3);
        tick();
        chk("rr_drained", 32'(pending), 32'd0);

        // Backpressure from a fresh pointer of 0.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        evt_ready = 1'b0;
        sw_edge = (NB'(1) << 2) | (NB'(1) << 9);
        tick();
        sw_edge = '0;
        tick();
        for (int c = 0; c < 10; c++) begin
            chk("bp_hold_valid", 32'(evt_valid), 32'd1);
            chk("bp_hold_idx", 32'(evt_idx), 32'd2);
            tick();
        end
        evt_ready = 1'b1;
        tick();
        chk("bp_accept_valid", 32'(evt_valid), 32'd0);
        chk("bp_accept_pending", 32'(pending), 32'h00200);
        tick();
        chk("bp_next_idx", 32'(evt_idx), 32'd9);
        tick();

        // Set-wins collision, then a genuine overrun.
        evt_ready = 1'b0;
        sw_edge = NB'(1) << 4;
        tick();
        sw_edge = '0;
        tick();
        chk("col_offer_idx", 32'(evt_idx), 32'd4);
        evt_ready = 1'b1;
        sw_edge = NB'(1) << 4;
        tick();
        sw_edge = '0;
        evt_ready = 1'b0;
        chk("col_pending", 32'(pending), 32'h00010);
        chk("col_valid", 32'(evt_valid), 32'd0);
        chk("col_ovr", 32'(overrun_cnt), 32'd0);
        tick();
        chk("col_reissue_valid", 32'(evt_valid), 32'd1);
        chk("col_reissue_idx", 32'(evt_idx), 32'd4);
        sw_edge = NB'(1) << 4;
        tick();
        sw_edge = '0;
        chk("ovr_one", 32'(overrun_cnt), 32'd1);
        evt_ready = 1'b1;
        tick();
        tick();
        chk("ovr_drain_pending", 32'(pending), 32'd0);
        chk("ovr_drain_valid", 32'(evt_valid), 32'd0);

        // Saturation: 300 dropped edges on top of the existing count of 1.
        evt_ready = 1'b0;
        sw_edge = NB'(1) << 7;
        tick();
        chk("sat_first_no_drop", 32'(overrun_cnt), 32'd1);
        for (int c = 0; c < 100; c++) tick();
        chk("sat_mid", 32'(overrun_cnt), 32'd101);
        for (int c = 0; c < 200; c++) tick();
        chk("sat_full", 32'(overrun_cnt), 32'd255);
        for (int c = 0; c < 5; c++) tick();
        chk("sat_hold", 32'(overrun_cnt), 32'd255);
        sw_edge = '0;
        evt_ready = 1'b1;
        tick();
        tick();
        chk("sat_drain_pending", 32'(pending), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
